// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
//   Serial pattern scanner. A pattern of 1..N bits (oldest bit at [len-1],
//   newest at bit 0) is matched against a qualified serial bit stream. Each
//   hit produces a one-cycle match pulse and bumps a saturating counter. When a
//   non-zero target count is reached, the run parks in DONE.
//
//   States: IDLE (accept config / start), FILL (collect the first len bits),
//           SCAN (compare on every valid bit), DONE (target reached).
//
// Build option:
//   SEQ_SCAN_NONOVERLAP_EN  defined   -> after each hit the window is flushed
//                                        and len fresh bits are needed again.
//                           undefined -> overlapping detection.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   cfg_valid    in   configuration offer
//   cfg_ready    out  high only in IDLE
//   cfg_pattern  in   [N-1:0] pattern
//   cfg_len      in   [LW-1:0] pattern length, legal 1..N
//   cfg_target   in   [CW-1:0] matches before DONE, 0 = unlimited
//   cfg_err      out  one-cycle pulse after an illegal cfg_len offer
//   start        in   begin a scan run
//   abort        in   end the run, return to IDLE
//   data_in      in   serial input bit
//   data_valid   in   data_in qualifier
//   match        out  one-cycle pulse per detected pattern
//   busy         out  high in FILL and SCAN
//   done         out  high in DONE
//   match_count  out  [CW-1:0] matches in current or last run
// -----------------------------------------------------------------------------
module seq_scan_ctrl #(
    parameter int N  = 8,
    parameter int CW = 8,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic [CW-1:0] cfg_target,
    output logic          cfg_err,
    input  logic          start,
    input  logic          abort,
    input  logic          data_in,
    input  logic          data_valid,
    output logic          match,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_count
);

`ifdef SEQ_SCAN_NONOVERLAP_EN
    localparam bit NONOVL = 1'b1;
`else
    localparam bit NONOVL = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Mask selecting the low len bits of the compare window.
    function automatic logic [N-1:0] len_mask(input logic [LW-1:0] len);
        logic [N-1:0] m;
        m = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    logic [N-2:0]  shift_r;
    logic [LW-1:0] fill_r;
    logic [N-1:0]  pat_r;
    logic [LW-1:0] len_r;
    logic [CW-1:0] tgt_r;
    logic [CW-1:0] count_r;
    logic          match_r;
    logic          cfg_err_r;
    logic          busy_r;
    logic          done_r;
    logic          cfg_ready_r;

    logic          cfg_fire_s;
    logic          cfg_ok_s;
    logic          run_start_s;
    logic          shift_en_s;
    logic          cmp_en_s;
    logic          hit_s;
    logic          tgt_hit_s;
    logic [N-1:0]  window_s;
    logic [CW-1:0] count_inc_s;
    logic          busy_s;
    logic          done_s;
    logic          cfg_ready_s;

    // The newest bit joins the window combinationally so a hit costs no extra cycle.
    assign window_s    = {shift_r, data_in};
    assign cfg_fire_s  = (state_r == ST_IDLE) && cfg_valid;
    assign cfg_ok_s    = (cfg_len != {LW{1'b0}}) && (cfg_len <= LW'(N));
    // A cfg handshake in IDLE swallows start; abort always beats start.
    assign run_start_s = start && !abort &&
                         (((state_r == ST_IDLE) && !cfg_valid) || (state_r == ST_DONE));
    assign shift_en_s  = ((state_r == ST_FILL) || (state_r == ST_SCAN)) && data_valid && !abort;
    assign cmp_en_s    = shift_en_s &&
                         ((state_r == ST_SCAN) || (fill_r == (len_r - LW'(1))));
    assign hit_s       = cmp_en_s &&
                         (((window_s ^ pat_r) & len_mask(len_r)) == {N{1'b0}});
    assign count_inc_s = (count_r == {CW{1'b1}}) ? count_r : (count_r + CW'(1));
    assign tgt_hit_s   = hit_s && (tgt_r != {CW{1'b0}}) && (count_inc_s == tgt_r);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_start_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL, ST_SCAN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (tgt_hit_s) begin
                    state_next_s = ST_DONE;
                end else if (hit_s && NONOVL) begin
                    state_next_s = ST_FILL;
                end else if (cmp_en_s) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (run_start_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the status outputs leave a register.
    always_comb begin
        busy_s      = 1'b0;
        done_s      = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_next_s)
            ST_IDLE: cfg_ready_s = 1'b1;
            ST_FILL: busy_s      = 1'b1;
            ST_SCAN: busy_s      = 1'b1;
            ST_DONE: done_s      = 1'b1;
            default: cfg_ready_s = 1'b1;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            busy_r      <= busy_s;
            done_r      <= done_s;
            cfg_ready_r <= cfg_ready_s;
        end
    end

    // Stored configuration and illegal-length error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            pat_r     <= {N{1'b0}};
            len_r     <= LW'(N);
            tgt_r     <= {CW{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            if (cfg_fire_s && cfg_ok_s) begin
                pat_r <= cfg_pattern;
                len_r <= cfg_len;
                tgt_r <= cfg_target;
            end
            cfg_err_r <= cfg_fire_s && !cfg_ok_s;
        end
    end

    // Run datapath: shift window, fill counter, match counter, match pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r <= {(N-1){1'b0}};
            fill_r  <= {LW{1'b0}};
            count_r <= {CW{1'b0}};
            match_r <= 1'b0;
        end else begin
            match_r <= hit_s;
            if (run_start_s) begin
                shift_r <= {(N-1){1'b0}};
                fill_r  <= {LW{1'b0}};
                count_r <= {CW{1'b0}};
            end else if (shift_en_s) begin
                if (hit_s && NONOVL) begin
                    // Non-overlapping: the matched bits are consumed.
                    shift_r <= {(N-1){1'b0}};
                    fill_r  <= {LW{1'b0}};
                end else begin
                    shift_r <= window_s[N-2:0];
                    if (state_r == ST_FILL) begin
                        fill_r <= fill_r + LW'(1);
                    end
                end
                if (hit_s) begin
                    count_r <= count_inc_s;
                end
            end
        end
    end

    assign match       = match_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign cfg_ready   = cfg_ready_r;
    assign cfg_err     = cfg_err_r;
    assign match_count = count_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;

    localparam int N  = 8;
    localparam int CW = 8;
    localparam int LW = 4;

    logic          clock;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [N-1:0]  cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_target;
    logic          cfg_err;
    logic          start;
    logic          abort;
    logic          data_in;
    logic          data_valid;
    logic          match;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_count;

    int   vectors;
    int   miscompares;
    logic exp_q[$];

    seq_scan_ctrl #(.N(N), .CW(CW), .LW(LW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_err     (cfg_err),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .match       (match),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one data cycle; the expected match for it goes into the scoreboard
    // and is popped once the DUT has produced its registered response.
    task automatic drive_bit(input logic d, input logic v, input logic ab, input logic exp_m);
        logic e;
        data_in    = d;
        data_valid = v;
        abort      = ab;
        exp_q.push_back(exp_m);
        tick();
        data_valid = 1'b0;
        abort      = 1'b0;
        e = exp_q.pop_front();
        check("match", {31'd0, match}, {31'd0, e});
    endtask

    task automatic do_cfg(input logic [LW-1:0] len, input logic [N-1:0] pat,
                          input logic [CW-1:0] tgt, input logic st);
        cfg_valid   = 1'b1;
        cfg_len     = len;
        cfg_pattern = pat;
        cfg_target  = tgt;
        start       = st;
        tick();
        cfg_valid   = 1'b0;
        start       = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        logic [6:0] seq40;
        logic [6:0] exp40;
        logic [3:0] exp45;
        int         cnt45;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_target  = 8'h00;
        start       = 1'b0;
        abort       = 1'b0;
        data_in     = 1'b0;
        data_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_count", {24'd0, match_count}, 32'd0);

        // len=4 pattern 0110, bits 0110110 -> hits after bits 4 and 7.
        do_cfg(4'd4, 8'b0110, 8'd0, 1'b0);
        check("cfg_ok_err", {31'd0, cfg_err}, 32'd0);
        do_start();
        check("fill_busy", {31'd0, busy}, 32'd1);
        check("fill_ready", {31'd0, cfg_ready}, 32'd0);
        seq40 = 7'b0110110;
        exp40 = 7'b0001001;
        for (int i = 6; i >= 0; i--) begin
            drive_bit(seq40[i], 1'b1, 1'b0, exp40[i]);
        end
        check("t40_count", {24'd0, match_count}, 32'd2);
        check("t40_busy", {31'd0, busy}, 32'd1);
        do_abort();
        check("abort_idle", {31'd0, cfg_ready}, 32'd1);
        check("abort_count_hold", {24'd0, match_count}, 32'd2);

        // Illegal lengths pulse cfg_err and leave 0110/len4 in place.
        do_cfg(4'd0, 8'hFF, 8'd1, 1'b0);
        check("len0_err", {31'd0, cfg_err}, 32'd1);
        do_cfg(4'd9, 8'hFF, 8'd1, 1'b0);
        check("len9_err", {31'd0, cfg_err}, 32'd1);
        tick();
        check("err_pulse_end", {31'd0, cfg_err}, 32'd0);
        do_start();
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b1);
        do_abort();

        // len=3 pattern 101 target 2: DONE after bit 5, then bits ignored.
        do_cfg(4'd3, 8'b101, 8'd2, 1'b0);
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
        check("t41_done", {31'd0, done}, 32'd1);
        check("t41_busy", {31'd0, busy}, 32'd0);
        check("t41_count", {24'd0, match_count}, 32'd2);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        check("t41_done_hold", {31'd0, done}, 32'd1);
        check("t41_count_hold", {24'd0, match_count}, 32'd2);
        do_start();
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_count", {24'd0, match_count}, 32'd0);

        // Abort on the final pattern bit suppresses the hit.
        do_abort();
        do_cfg(4'd3, 8'b101, 8'd0, 1'b0);
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0);
        check("t44_idle", {31'd0, cfg_ready}, 32'd1);
        check("t44_busy", {31'd0, busy}, 32'd0);
        check("t44_count", {24'd0, match_count}, 32'd1);
        // start+abort together: abort wins, in IDLE and in FILL.
        start = 1'b1;
        do_abort();
        check("sa_idle_busy", {31'd0, busy}, 32'd0);
        do_start();
        check("sa_fill_busy", {31'd0, busy}, 32'd1);
        start = 1'b1;
        do_abort();
        check("sa_fill_idle", {31'd0, cfg_ready}, 32'd1);

        // Config and start together: config taken, start ignored.
        do_cfg(4'd2, 8'b11, 8'd0, 1'b1);
        check("cfg_start_busy", {31'd0, busy}, 32'd0);
        check("cfg_start_ready", {31'd0, cfg_ready}, 32'd1);

        // Invalid cycles do not shift.
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
        check("t43_count", {24'd0, match_count}, 32'd1);
        do_abort();

        // Pattern 11 against 1111.
`ifdef SEQ_SCAN_NONOVERLAP_EN
        exp45 = 4'b0101;
        cnt45 = 2;
`else
        exp45 = 4'b0111;
        cnt45 = 3;
`endif
        do_start();
        for (int i = 3; i >= 0; i--) begin
            drive_bit(1'b1, 1'b1, 1'b0, exp45[i]);
        end
        check("t45_count", {24'd0, match_count}, cnt45);
        do_abort();

        // Saturation: len=1 pattern 1, 260 ones.
        do_cfg(4'd1, 8'b1, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 260; i++) begin
            drive_bit(1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("sat_count", {24'd0, match_count}, 32'd255);
        do_abort();

        // Reset mid-run: no match, defaults restored (len=8, pattern=0).
        do_cfg(4'd3, 8'b111, 8'd0, 1'b0);
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive_bit(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_run_count", {24'd0, match_count}, 32'd0);
        do_start();
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0, 1'b1, 1'b0, (i == 7) ? 1'b1 : 1'b0);
        end
        check("dflt_count", {24'd0, match_count}, 32'd1);
        check("dflt_done", {31'd0, done}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
